complex_matrix_multiplier: RTL and testbench
============================================

Name: complex_matrix_multiplier

Overview:
Responder end of the sequence-multiplier/multiplier handshake. Computes the 2x2 complex fixed-point product C = A x B.
- Latches mtx_a and mtx_b on a ready strobe.
- Runs a time-multiplexed complex multiply-accumulate over 8 cycles.
- Presents the saturated result with a one-cycle done pulse.
- Sits between sequence_multiplier (initiator) and the solution/duplicate checkers, which consume its result via sequence_multiplier's cache.

Parameters:
NUMERIC_BITS, 18, width of one signed real or imaginary component (two's complement).
FRAC_BITS, 16, fractional bits of each component (Q2.16 by default; representable range [-2, 2)).

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
mtx_a  input  NUMERIC_BITS x [1:0][1:0][1:0]  left operand; indices are [row][col][0=real,1=imag]
mtx_b  input  NUMERIC_BITS x [1:0][1:0][1:0]  right operand, same layout
ready  input  1  start strobe from initiator; sampled only when busy=0
busy  output  1  high from the cycle after an accepted ready until the cycle after done
done  output  1  one-cycle pulse; result is valid from this cycle on
overflow  output  1  valid with done; high if any result component saturated
result  output  NUMERIC_BITS x [1:0][1:0][1:0]  product matrix, same layout

Behaviour:
- Clocking: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE; busy=0; done=0; overflow=0; all result components=0; internal operand, accumulator and staging registers cleared. Reset overrides every other event, including mid-operation: the operation is aborted, no done is issued, and no partial result reaches result.
- States: IDLE, MULT, DONE.
- IDLE: if ready=1 at edge T, copy mtx_a/mtx_b into internal operand registers, clear the element/k counters, and go to MULT. Input ports are not sampled again until the next accepted ready.
- MULT: 8 cycles (edges T+1..T+8). Each cycle handles element (i,j) with index k:
  - Element order: (0,0), (0,1), (1,0), (1,1); k = 0 then 1.
  - Compute one complex product p = A[i][k]*B[k][j]:
    - re = ar*br - ai*bi
    - im = ar*bi + ai*br
  - Each real product is a full 2*NUMERIC_BITS signed value; accumulate at 2*NUMERIC_BITS+2 bits.
  - k=0 loads the accumulator with p; k=1 adds p and writes the finished element into the staging matrix.
- Element scaling, applied on the k=1 write:
  - Arithmetic shift right by FRAC_BITS (floor, no rounding).
  - Saturate to [-2^(NUMERIC_BITS-1), 2^(NUMERIC_BITS-1)-1], i.e. [-131072, 131071] at defaults.
  - Set a sticky saturation flag if clamping occurred.
- After the k=1 cycle of element (1,1), go to DONE.
- DONE (edge T+9): copy staging matrix to result, set done=1, overflow=sticky flag, go to IDLE. done and overflow are single-cycle; overflow returns to 0 with done.
- result changes only on the DONE edge and holds until the next DONE or reset.
- Latency: ready sampled at edge T -> done high in the cycle after edge T+9. Throughput: one product per 10 cycles.
- busy = (state != IDLE). ready while busy=1 (including the DONE cycle) is ignored and never queued.
- Operand changes on mtx_a/mtx_b after acceptance do not affect the running product.

Test Plan:
- Identity: A=I (65536 on diagonal reals, all else 0), B arbitrary (e.g. B[0][1] real=12345, imag=-777) -> result==B exactly; done high one cycle, 10 cycles after the ready edge; overflow=0.
- H*H: all A/B reals ±46341 (H = [[1,1],[1,-1]]/sqrt2), imag 0 -> diagonal real=65536, off-diagonal 0, all imag 0.
- S*S: S = diag(1, i) (A[1][1] imag=65536) -> result[0][0] real=65536, result[1][1] real=-65536, all other components 0.
- Saturation: A=B=1.5*I (98304) -> diagonal real=131071, overflow=1; A=-1.5*I, B=1.5*I -> diagonal real=-131072, overflow=1.
- Busy ignore: second ready pulse at cycles T+3 and T+9 with different operands -> exactly one done, result from first operands, busy falls after done.
- Reset at T+5 -> no done; busy=0 and result=0 the next cycle; a fresh ready then completes normally in 10 cycles.

Source files
------------

// File: rtl/complex_matrix_multiplier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// complex_matrix_multiplier : 2x2 complex fixed-point C = A x B, one MAC/cycle
// Revision: 1.0
// ---------------------------------------------------------------------------
module complex_matrix_multiplier #(
  parameter int NUMERIC_BITS = 18,
  parameter int FRAC_BITS    = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [1:0][1:0][1:0][NUMERIC_BITS-1:0]     mtx_a,
  input  logic [1:0][1:0][1:0][NUMERIC_BITS-1:0]     mtx_b,
  input  logic                                       ready,
  output logic                                       busy,
  output logic                                       done,
  output logic                                       overflow,
  output logic [1:0][1:0][1:0][NUMERIC_BITS-1:0]     result
);

  localparam int N  = NUMERIC_BITS;
  localparam int PW = 2 * NUMERIC_BITS;
  localparam int AW = 2 * NUMERIC_BITS + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic [1:0][1:0][1:0][N-1:0] mtx_t;

  state_t                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  mtx_t                  a_q, a_d, b_q, b_d, stage_q, stage_d, result_q, result_d;
  logic signed [AW-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic                  sat_q, sat_d;
  logic                  busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;

  logic                  w_i, w_j, w_k;
  logic signed [N-1:0]   ar, ai, br, bi;
  logic signed [PW-1:0]  ar_x, ai_x, br_x, bi_x;
  logic signed [PW-1:0]  p_rr, p_ii, p_ri, p_ir;
  logic signed [AW-1:0]  rr_x, ii_x, ri_x, ir_x;
  logic signed [AW-1:0]  p_re, p_im, sum_re, sum_im;
  logic [N:0]            sc_re, sc_im;

  // Returns {clamped, value}: floor shift by FRAC_BITS then clamp to N bits.
  function automatic logic [N:0] scale(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] s;
    s = v >>> FRAC_BITS;
    if ((&s[AW-1:N-1]) || !(|s[AW-1:N-1]))
      return {1'b0, s[N-1:0]};
    else if (s[AW-1])
      return {1'b1, 1'b1, {(N-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(N-1){1'b1}}};
  endfunction

  always_comb begin
    w_i  = cnt_q[2];
    w_j  = cnt_q[1];
    w_k  = cnt_q[0];
    ar   = a_q[w_i][w_k][0];
    ai   = a_q[w_i][w_k][1];
    br   = b_q[w_k][w_j][0];
    bi   = b_q[w_k][w_j][1];
    ar_x = {{(PW-N){ar[N-1]}}, ar};
    ai_x = {{(PW-N){ai[N-1]}}, ai};
    br_x = {{(PW-N){br[N-1]}}, br};
    bi_x = {{(PW-N){bi[N-1]}}, bi};
    p_rr = ar_x * br_x;
    p_ii = ai_x * bi_x;
    p_ri = ar_x * bi_x;
    p_ir = ai_x * br_x;
    rr_x = {{(AW-PW){p_rr[PW-1]}}, p_rr};
    ii_x = {{(AW-PW){p_ii[PW-1]}}, p_ii};
    ri_x = {{(AW-PW){p_ri[PW-1]}}, p_ri};
    ir_x = {{(AW-PW){p_ir[PW-1]}}, p_ir};
    p_re   = rr_x - ii_x;
    p_im   = ri_x + ir_x;
    sum_re = acc_re_q + p_re;
    sum_im = acc_im_q + p_im;
    sc_re  = scale(sum_re);
    sc_im  = scale(sum_im);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    stage_d    = stage_q;
    result_d   = result_q;
    acc_re_d   = acc_re_q;
    acc_im_d   = acc_im_q;
    sat_d      = sat_q;
    done_d     = 1'b0;
    overflow_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ready) begin
          a_d     = mtx_a;
          b_d     = mtx_b;
          cnt_d   = 3'd0;
          sat_d   = 1'b0;
          state_d = MULT;
        end
      end
      MULT: begin
        if (!w_k) begin
          acc_re_d = p_re;
          acc_im_d = p_im;
        end else begin
          stage_d[w_i][w_j][0] = sc_re[N-1:0];
          stage_d[w_i][w_j][1] = sc_im[N-1:0];
          sat_d = sat_q | sc_re[N] | sc_im[N];
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = DONE;
      end
      DONE: begin
        result_d   = stage_q;
        done_d     = 1'b1;
        overflow_d = sat_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      stage_q    <= '0;
      result_q   <= '0;
      acc_re_q   <= '0;
      acc_im_q   <= '0;
      sat_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      stage_q    <= stage_d;
      result_q   <= result_d;
      acc_re_q   <= acc_re_d;
      acc_im_q   <= acc_im_d;
      sat_q      <= sat_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;
  assign result   = result_q;

endmodule
`default_nettype wire

// File: tb/tb_complex_matrix_multiplier.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_complex_matrix_multiplier : random + directed bench with integer model
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_complex_matrix_multiplier;

  localparam int N = 18;
  localparam int F = 16;
  localparam longint MAXV = 131071;
  localparam longint MINV = -131072;

  typedef logic [1:0][1:0][1:0][N-1:0] mtx_t;

  logic clk = 1'b0;
  logic reset, ready, busy, done, overflow;
  mtx_t mtx_a, mtx_b, result;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  complex_matrix_multiplier #(.NUMERIC_BITS(N), .FRAC_BITS(F)) dut (
    .clk      (clk),
    .reset    (reset),
    .mtx_a    (mtx_a),
    .mtx_b    (mtx_b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .result   (result)
  );

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [63:0] sx(input logic [N-1:0] x);
    logic signed [N-1:0] s;
    s = x;
    return s;
  endfunction

  function automatic longint floor_div(input longint x);
    longint d, q;
    d = longint'(1) << F;
    q = x / d;
    if (x < 0 && q * d != x) q = q - 1;
    return q;
  endfunction

  function automatic longint clampv(input longint x, inout logic ov);
    if (x > MAXV) begin ov = 1'b1; return MAXV; end
    if (x < MINV) begin ov = 1'b1; return MINV; end
    return x;
  endfunction

  // Plain complex matrix product in 64-bit integers.
  function automatic void model(input mtx_t a, input mtx_t b, output mtx_t r, output logic ov);
    longint re, im, ar, ai, br, bi, t;
    ov = 1'b0;
    r  = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        re = 0;
        im = 0;
        for (int k = 0; k < 2; k++) begin
          ar = sx(a[i][k][0]);
          ai = sx(a[i][k][1]);
          br = sx(b[k][j][0]);
          bi = sx(b[k][j][1]);
          re = re + ar * br - ai * bi;
          im = im + ar * bi + ai * br;
        end
        t = clampv(floor_div(re), ov);
        r[i][j][0] = t[N-1:0];
        t = clampv(floor_div(im), ov);
        r[i][j][1] = t[N-1:0];
      end
    end
  endfunction

  function automatic mtx_t rnd_mtx(input int mode);
    mtx_t m;
    logic [31:0] u;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int c = 0; c < 2; c++) begin
          if (mode == 0) u = $urandom;
          else u = 32'($urandom_range(0, 131072)) - 32'd65536;
          m[i][j][c] = u[N-1:0];
        end
    return m;
  endfunction

  task automatic run_op(input mtx_t a, input mtx_t b, input bit inject, input string name);
    mtx_t er;
    logic eov;
    int n, extra;
    model(a, b, er, eov);
    @(negedge clk);
    mtx_a = a;
    mtx_b = b;
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    n = 0;
    chk({name, "_busy_start"}, busy, 1);
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        mtx_a = rnd_mtx(0);
        mtx_b = rnd_mtx(0);
      end
      ready = inject && (n == 2 || n == 8);
    end
    ready = 1'b0;
    chk({name, "_latency"}, n, 9);
    chk({name, "_done"}, done, 1);
    chk({name, "_busy_at_done"}, busy, 0);
    chk({name, "_overflow"}, overflow, eov);
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++)
        for (int c = 0; c < 2; c++)
          chk($sformatf("%s_r%0d%0d%0d", name, i, j, c), sx(result[i][j][c]), sx(er[i][j][c]));
    @(negedge clk);
    chk({name, "_done_pulse"}, done, 0);
    chk({name, "_ovf_pulse"}, overflow, 0);
    if (inject) begin
      extra = 0;
      for (int t = 0; t < 14; t++) begin
        @(negedge clk);
        if (done) extra++;
      end
      chk({name, "_extra_done"}, extra, 0);
      chk({name, "_busy_after"}, busy, 0);
    end
  endtask

  initial begin
    mtx_t a, b;
    logic [N-1:0] hp, hn, one, onep5, m1p5;
    int dn;

    reset = 1'b1;
    ready = 1'b0;
    mtx_a = '0;
    mtx_b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_ovf", overflow, 0);
    chk("reset_result", |result, 0);

    one   = 18'd65536;
    onep5 = 18'd98304;
    m1p5  = -onep5;
    hp    = 18'd46341;
    hn    = -hp;

    a = '0; a[0][0][0] = one; a[1][1][0] = one;
    b = rnd_mtx(0); b[0][1][0] = 18'd12345; b[0][1][1] = -18'd777;
    run_op(a, b, 1'b0, "ident");
    chk("ident_b01re", sx(result[0][1][0]), 12345);
    chk("ident_b01im", sx(result[0][1][1]), -777);

    a = '0; a[0][0][0] = hp; a[0][1][0] = hp; a[1][0][0] = hp; a[1][1][0] = hn;
    run_op(a, a, 1'b0, "hh");
    chk("hh_00re", sx(result[0][0][0]), 65536);
    chk("hh_01re", sx(result[0][1][0]), 0);

    a = '0; a[0][0][0] = one; a[1][1][1] = one;
    run_op(a, a, 1'b0, "ss");
    chk("ss_11re", sx(result[1][1][0]), -65536);

    a = '0; a[0][0][0] = onep5; a[1][1][0] = onep5;
    run_op(a, a, 1'b0, "satp");
    chk("satp_00re", sx(result[0][0][0]), 131071);

    b = '0; b[0][0][0] = m1p5; b[1][1][0] = m1p5;
    run_op(b, a, 1'b0, "satn");
    chk("satn_00re", sx(result[0][0][0]), -131072);

    run_op(rnd_mtx(1), rnd_mtx(1), 1'b1, "busyign");

    // Abort mid-operation: reset sampled at edge T+5.
    @(negedge clk);
    mtx_a = rnd_mtx(1);
    mtx_b = rnd_mtx(1);
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", |result, 0);
    reset = 1'b0;
    dn = 0;
    for (int t = 0; t < 14; t++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("abort_no_done", dn, 0);
    run_op(rnd_mtx(1), rnd_mtx(1), 1'b0, "after_abort");

    for (int r = 0; r < 10; r++)
      run_op(rnd_mtx(r % 2), rnd_mtx((r / 2) % 2), 1'b0, $sformatf("rnd%0d", r));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
